// File: rtl/jtpang_objdma.sv
// Object-attribute DMA: takes the Z80 bus and copies 2^AW bytes of object RAM into the object buffer.
// Optional bus-grant timeout enabled by defining JTPANG_DMA_TIMEOUT_EN.
module jtpang_objdma #(
    parameter int AW  = 9,
    parameter int TOW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          dma_go,
    output logic          busrq,
    input  logic          busak_n,
    output logic [AW-1:0] src_addr,
    input  logic [7:0]    src_dout,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_din,
    output logic          buf_we,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_COPY = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          go_pend_q, go_pend_d;
    logic          busrq_q, busrq_d;
    logic [AW-1:0] src_addr_q, src_addr_d;
    logic [AW-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]    buf_din_q, buf_din_d;
    logic          buf_we_q, buf_we_d;
    logic          done_q, done_d;
    logic          rd_pend_q, rd_pend_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] wr_addr;

    // The outstanding read always belongs to the address just before src_addr.
    assign wr_addr = src_addr_q - {{(AW-1){1'b0}}, 1'b1};

`ifdef JTPANG_DMA_TIMEOUT_EN
    localparam logic [TOW-1:0] TO_LAST = TOW'((1 << TOW) - 2);
    logic           err_q, err_d;
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        go_pend_d  = go_pend_q;
        busrq_d    = busrq_q;
        src_addr_d = src_addr_q;
        buf_addr_d = buf_addr_q;
        buf_din_d  = buf_din_q;
        buf_we_d   = 1'b0;
        done_d     = 1'b0;
        rd_pend_d  = rd_pend_q;
        cnt_d      = cnt_q;
`ifdef JTPANG_DMA_TIMEOUT_EN
        err_d      = err_q;
        to_cnt_d   = to_cnt_q;
`endif
        if (state_q == ST_IDLE && dma_go) go_pend_d = 1'b1;
        if (cen) begin
            case (state_q)
                ST_IDLE: if (go_pend_q) begin
                    state_d   = ST_REQ;
                    go_pend_d = 1'b0;
                    busrq_d   = 1'b1;
`ifdef JTPANG_DMA_TIMEOUT_EN
                    err_d     = 1'b0;
                    to_cnt_d  = '0;
`endif
                end
                ST_REQ: if (!busak_n) begin
                    state_d    = ST_COPY;
                    src_addr_d = '0;
                    cnt_d      = '0;
                    rd_pend_d  = 1'b0;
                end
`ifdef JTPANG_DMA_TIMEOUT_EN
                else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        busrq_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
`endif
                ST_COPY: begin
                    if (rd_pend_q) begin
                        buf_addr_d = wr_addr;
                        buf_din_d  = src_dout;
                        buf_we_d   = 1'b1;
                        if (wr_addr == '1) state_d = ST_REL;
                    end
                    // cnt MSB set means every address has already been read.
                    rd_pend_d = !cnt_q[AW];
                    if (!cnt_q[AW]) begin
                        src_addr_d = src_addr_q + 1'b1;
                        cnt_d      = cnt_q + 1'b1;
                    end
                end
                default: begin
                    busrq_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            go_pend_q  <= 1'b0;
            busrq_q    <= 1'b0;
            src_addr_q <= '0;
            buf_addr_q <= '0;
            buf_din_q  <= '0;
            buf_we_q   <= 1'b0;
            done_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            go_pend_q  <= go_pend_d;
            busrq_q    <= busrq_d;
            src_addr_q <= src_addr_d;
            buf_addr_q <= buf_addr_d;
            buf_din_q  <= buf_din_d;
            buf_we_q   <= buf_we_d;
            done_q     <= done_d;
            rd_pend_q  <= rd_pend_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef JTPANG_DMA_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            err_q    <= err_d;
            to_cnt_q <= to_cnt_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busrq    = busrq_q;
    assign src_addr = src_addr_q;
    assign buf_addr = buf_addr_q;
    assign buf_din  = buf_din_q;
    assign buf_we   = buf_we_q;
    assign busy     = state_q != ST_IDLE;
    assign done     = done_q;

endmodule
